// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle MULT/MULTU/DIV/DIVU sequencer for the execute stage.
// It owns the HI/LO write port for these ops and stalls the pipeline while busy.
// Optional feature macro: MULDIV_DIV0_FAST_EN. When it is defined, a divide by zero
// skips the 32 divide steps and writes HI/LO in the cycle after accept.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a mul/div op from the issue slot
// MUL   | multiply in flight, counting fixed latency
// DIV   | restoring divide in flight, one quotient bit per cycle
// DONE  | HI/LO write strobe asserted for one cycle

`ifndef ALUOP_MULT
`define ALUOP_MULT  8'b00011000
`endif
`ifndef ALUOP_MULTU
`define ALUOP_MULTU 8'b00011001
`endif
`ifndef ALUOP_DIV
`define ALUOP_DIV   8'b00011010
`endif
`ifndef ALUOP_DIVU
`define ALUOP_DIVU  8'b00011011
`endif

module muldiv_ctrl #(
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        start,
  input  logic [7:0]  aluop,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        stall,
  output logic        hilo_we,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy
);

  localparam int CW = $clog2(33);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   opa_q, opa_d;
  logic [31:0]   opb_q, opb_d;
  logic          is_div_q, is_div_d;
  logic          is_signed_q, is_signed_d;
  // {remainder, quotient} while dividing, {HI, LO} product once multiply completes
  logic [63:0]   acc_q, acc_d;
  logic [31:0]   dvsr_q, dvsr_d;

  logic          op_mult, op_multu, op_div_s, op_divu;
  logic          valid_op, op_div, op_signed, accept, div0_fast;
  logic [63:0]   prod;
  logic [32:0]   div_shift, div_trial;
  logic [63:0]   div_acc_next;
  logic [31:0]   res_hi, res_lo;
  logic [31:0]   quo_fix, rem_fix;

  function automatic logic [31:0] mag(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? (~x + 32'd1) : x;
  endfunction

  assign op_mult   = (aluop == `ALUOP_MULT);
  assign op_multu  = (aluop == `ALUOP_MULTU);
  assign op_div_s  = (aluop == `ALUOP_DIV);
  assign op_divu   = (aluop == `ALUOP_DIVU);
  assign valid_op  = op_mult | op_multu | op_div_s | op_divu;
  assign op_div    = op_div_s | op_divu;
  assign op_signed = op_mult | op_div_s;
  assign accept    = (state_q == S_IDLE) & start & valid_op & ~flush;

`ifdef MULDIV_DIV0_FAST_EN
  assign div0_fast = op_div & (src_b == 32'd0);
`else
  assign div0_fast = 1'b0;
`endif

  // Low 64 bits of the product of sign- or zero-extended operands give the signed or unsigned result.
  assign prod = (is_signed_q ? {{32{opa_q[31]}}, opa_q} : {32'd0, opa_q}) *
                (is_signed_q ? {{32{opb_q[31]}}, opb_q} : {32'd0, opb_q});

  // One restoring step: shift the next dividend bit into the partial remainder and try to subtract.
  assign div_shift    = {acc_q[63:32], acc_q[31]};
  assign div_trial    = div_shift - {1'b0, dvsr_q};
  assign div_acc_next = div_trial[32] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                                      : {div_trial[31:0], acc_q[30:0], 1'b1};

  // Final HI/LO: raw product, divide-by-zero constants, or sign-corrected quotient/remainder.
  always_comb begin
    res_hi  = acc_q[63:32];
    res_lo  = acc_q[31:0];
    quo_fix = acc_q[31:0];
    rem_fix = acc_q[63:32];
    if (is_div_q) begin
      if (opb_q == 32'd0) begin
        res_hi = opa_q;
        res_lo = (is_signed_q && opa_q[31]) ? 32'h0000_0001 : 32'hFFFF_FFFF;
      end else begin
        if (is_signed_q && (opa_q[31] ^ opb_q[31])) quo_fix = ~acc_q[31:0] + 32'd1;
        if (is_signed_q && opa_q[31])               rem_fix = ~acc_q[63:32] + 32'd1;
        res_hi = rem_fix;
        res_lo = quo_fix;
      end
    end
  end

  // Next-state and datapath update; a flush always returns to IDLE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    is_div_d    = is_div_q;
    is_signed_d = is_signed_q;
    acc_d       = acc_q;
    dvsr_d      = dvsr_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          opa_d       = src_a;
          opb_d       = src_b;
          is_div_d    = op_div;
          is_signed_d = op_signed;
          cnt_d       = '0;
          acc_d       = {32'd0, op_div ? mag(src_a, op_signed) : 32'd0};
          dvsr_d      = mag(src_b, op_signed);
          if (div0_fast)   state_d = S_DONE;
          else if (op_div) state_d = S_DIV;
          else             state_d = S_MUL;
        end
      end
      S_MUL: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(MUL_CYCLES - 2)) begin
          acc_d   = prod;
          state_d = S_DONE;
        end
      end
      S_DIV: begin
        acc_d = div_acc_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(31)) state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (flush) state_d = S_IDLE;
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      is_div_q    <= 1'b0;
      is_signed_q <= 1'b0;
      acc_q       <= '0;
      dvsr_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      is_div_q    <= is_div_d;
      is_signed_q <= is_signed_d;
      acc_q       <= acc_d;
      dvsr_q      <= dvsr_d;
    end
  end

  // Results are gated to zero outside the write strobe so stale values never leak.
  assign busy    = (state_q != S_IDLE);
  assign hilo_we = (state_q == S_DONE) & ~flush;
  assign stall   = ~flush & (((state_q == S_IDLE) & start & valid_op) |
                             (state_q == S_MUL) | (state_q == S_DIV));
  assign hi_o    = hilo_we ? res_hi : 32'd0;
  assign lo_o    = hilo_we ? res_lo : 32'd0;

endmodule
